// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one asynchronous-read data-memory port between the CPU
// and a read-only debug/display port. The CPU has priority; the debug port is
// serviced in idle CPU cycles.
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to compile in the debug
// starvation guard, which forces a debug slot after STARVE_MAX consecutive
// denied debug-request cycles.
module dmem_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_valid,
  output logic [31:0] dbg_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Owner of the dmem port in the previous cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_DBG  = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cpu_rdata_q;
  logic [31:0] cpu_rdata_d;
  logic [31:0] dbg_rdata_q;
  logic [31:0] dbg_rdata_d;

  logic        cpu_grant_s;
  logic        dbg_grant_s;
  logic        force_dbg_s;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  // Saturation point of the starvation counter; legal range is 1..255.
  localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;

  // A debug slot is forced once the debug port has waited STARVE_MAX cycles.
  assign force_dbg_s = (starve_cnt_q == STARVE_LIMIT);

  // Count consecutive denied debug-request cycles; any grant or a dropped
  // request restarts the count from zero.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg_req || dbg_grant_s) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // The CPU is stalled only when it asked and the debug port was forced in.
  assign cpu_stall = cpu_req & ~cpu_grant_s;
`else
  // Without the guard the CPU always wins, so it never stalls; the depth
  // parameter has no effect in this build.
  logic unused_starve_cfg_s;

  assign force_dbg_s         = 1'b0;
  assign unused_starve_cfg_s = (STARVE_MAX > 0);
  assign cpu_stall           = 1'b0;
`endif

  // Fixed-priority grant: forced debug, then CPU, then debug in idle cycles.
  always_comb begin
    cpu_grant_s = 1'b0;
    dbg_grant_s = 1'b0;
    if (force_dbg_s && dbg_req) begin
      dbg_grant_s = 1'b1;
    end else if (cpu_req) begin
      cpu_grant_s = 1'b1;
    end else if (dbg_req) begin
      dbg_grant_s = 1'b1;
    end else begin
      cpu_grant_s = 1'b0;
      dbg_grant_s = 1'b0;
    end
  end

  // Steer the dmem port; only a granted CPU may ever drive a store.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    if (cpu_grant_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant_s) begin
      mem_we    = 1'b0;
      mem_addr  = dbg_addr;
      mem_wdata = 32'h0000_0000;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
    end
  end

  // Next owner and read-data capture for whichever side holds the port.
  always_comb begin
    state_d     = S_IDLE;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (dbg_grant_s) begin
      state_d     = S_DBG;
      dbg_rdata_d = mem_rdata;
    end else if (cpu_grant_s) begin
      state_d = S_CPU;
      if (!cpu_we) begin
        cpu_rdata_d = mem_rdata;
      end else begin
        cpu_rdata_d = cpu_rdata_q;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // Owner FSM and registered read-data outputs; reset drops any pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cpu_rdata_q <= 32'h0000_0000;
      dbg_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_gnt   = dbg_grant_s;
  assign dbg_valid = (state_q == S_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001: The module SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive denied debug-request cycles before a debug slot is forced (legal range 1..255).
REQ-002: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003: Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004: Port cpu_req, input, 1 bit: the CPU requests a data-memory access this cycle.
REQ-005: Port cpu_we, input, 1 bit: the CPU access is a store.
REQ-006: Ports cpu_addr and cpu_wdata, inputs, 32 bits each: the CPU address and store data.
REQ-007: Port cpu_stall, output, 1 bit: the CPU access was not serviced this cycle and must be held.
REQ-008: Port cpu_rdata, output, 32 bits: the registered CPU load data (the Wreg stage).
REQ-009: Ports dbg_req (1 bit) and dbg_addr (32 bits), inputs: a read-only debug/display request and its address.
REQ-010: Port dbg_gnt, output, 1 bit: the debug request is granted this cycle.
REQ-011: Port dbg_valid, output, 1 bit: one-cycle pulse marking dbg_rdata as valid.
REQ-012: Port dbg_rdata, output, 32 bits: the registered debug read data.
REQ-013: Ports mem_we (1 bit), mem_addr (32 bits) and mem_wdata (32 bits), outputs, are the dmem port; mem_rdata (32 bits) is an input carrying asynchronous-read data from dmem.

Function
REQ-014: Grant SHALL be decided combinationally every cycle:
- force_dbg=1 and dbg_req=1: grant DBG.
- otherwise cpu_req=1: grant CPU.
- otherwise dbg_req=1: grant DBG.
- otherwise: no grant.
REQ-015: When CPU is granted, the dmem port SHALL be driven as mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we.
REQ-016: When DBG is granted, the dmem port SHALL be driven as mem_addr=dbg_addr, mem_we=0, mem_wdata=0.
REQ-017: With no grant, mem_we SHALL be 0, mem_addr 0 and mem_wdata 0.
REQ-018: A store SHALL never reach dmem in a cycle where the CPU is not granted.
REQ-019: cpu_stall SHALL equal cpu_req AND NOT cpu_grant.
REQ-020: dbg_gnt SHALL equal dbg_grant.
REQ-021: On each rising clk edge with CPU granted and cpu_we=0, cpu_rdata SHALL load mem_rdata; otherwise cpu_rdata holds (1-cycle latency).
REQ-022: On each rising edge with DBG granted, dbg_rdata SHALL load mem_rdata and dbg_valid SHALL be 1 in the following cycle; otherwise dbg_valid=0 and dbg_rdata holds.
REQ-023: The FSM state SHALL record the previous cycle's owner:
- Encodings: S_IDLE=2'b00, S_CPU=2'b01, S_DBG=2'b10.
- Next state is the owner granted this cycle.
- dbg_valid is 1 exactly when state==S_DBG.
REQ-024: starve_cnt (8 bits) SHALL behave as follows:
- Increments when dbg_req=1 and DBG is not granted.
- Clears when DBG is granted or dbg_req=0.
- Saturates at STARVE_MAX.
REQ-025: force_dbg SHALL be defined as (starve_cnt==STARVE_MAX).
REQ-026: When dbg_req drops while force_dbg=1, no DBG grant SHALL occur, and the counter SHALL clear on the next edge.
REQ-027: Address bits SHALL pass through unmodified; the arbiter performs no alignment checking.

Reset
REQ-028: Asserting reset SHALL immediately set state=S_IDLE, starve_cnt=0, cpu_rdata=0, dbg_rdata=0 and dbg_valid=0, regardless of clk.
REQ-029: Reset asserted mid-operation SHALL discard any pending debug result, with no dbg_valid pulse after deassertion.
REQ-030: During reset, the combinational outputs SHALL follow REQ-014 to REQ-020 using starve_cnt=0.

Configuration
REQ-031: The macro DMEM_ARB_STARVE_GUARD_EN, when defined, SHALL compile in starve_cnt, force_dbg and the REQ-024 to REQ-026 behaviour.
REQ-032: When DMEM_ARB_STARVE_GUARD_EN is undefined:
- force_dbg is tied to 0 and there is no counter logic.
- The CPU always wins, and cpu_stall is constant 0.
- The debug port is serviced only in cycles with cpu_req=0.

Verification
REQ-033: Reset with cpu_req=0 and dbg_req=0 -> cpu_rdata=0, dbg_valid=0, mem_we=0, cpu_stall=0.
REQ-034: CPU store then load: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF; next cycle we=0, addr=0x10 -> mem_we=1 only in the first cycle; cpu_rdata=0xDEADBEEF one edge after the load cycle.
REQ-035: Idle CPU, dbg_req=1, dbg_addr=0x20 holding 0x12345678 -> dbg_gnt=1 in the same cycle; dbg_valid=1 and dbg_rdata=0x12345678 in the next cycle only.
REQ-036: With the guard enabled and STARVE_MAX=8, hold cpu_req=1 and dbg_req=1:
- dbg_gnt=0 for 8 cycles.
- In the 9th cycle: dbg_gnt=1, cpu_stall=1, mem_we=0 even if cpu_we=1.
- The counter then clears and the CPU regains the port.
REQ-037: Guard enabled, 5 denied cycles, then dbg_req=0 for one cycle, then dbg_req=1 again -> the force occurs 8 denied cycles later, not 3.
REQ-038: Assert reset while state==S_DBG and starve_cnt=4 -> dbg_valid=0 immediately and starve_cnt=0; no dbg_valid pulse after release.
